pc_sequencer: RTL and testbench

//  Generates the 5-bit program counter consumed by the fetch-side PC address latch.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/pc_sequencer_next_calc.sv | 50 +++++
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encodings
// and the default PC width.
package pc_sequencer_pkg;

  localparam int PC_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// Next-pc calculation: priority mux (jump > branch > pending > step/hold)
// plus the adders for the relative branch and the sequential increment.
// Also reports the redirect target so the caller can park it when no
// transfer happens.
module pc_next_calc #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jmp_take,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_off,
  input  logic              pend_v,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic              step,
  output logic              redir_v,
  output logic [ADDR_W-1:0] redir_addr,
  output logic [ADDR_W-1:0] nxt_pc,
  output logic              nxt_wrap
);

  logic signed [ADDR_W-1:0] br_off_s;
  logic        [ADDR_W-1:0] br_tgt;
  logic        [ADDR_W-1:0] seq_pc;

  // Branch target and sequential step both wrap modulo 2**ADDR_W.
  always_comb begin
    br_off_s = br_off;
    br_tgt   = pc + ADDR_W'(br_off_s);
    seq_pc   = pc + ADDR_W'(1);
  end

  // Priority selection; wrap is flagged only for a genuine sequential step.
  always_comb begin
    redir_v    = jmp_take | br_take;
    redir_addr = jmp_take ? jmp_addr : br_tgt;
    nxt_wrap   = 1'b0;
    if (redir_v) begin
      nxt_pc = redir_addr;
    end else if (pend_v) begin
      nxt_pc = pend_addr;
    end else if (step) begin
      nxt_pc   = seq_pc;
      nxt_wrap = &pc;
    end else begin
      nxt_pc = pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the instruction-fetch path. Offers each pc
// with a valid/ready handshake, steps sequentially, redirects on branch or
// jump (parking redirects that arrive without a transfer), and supports
// halt/resume with an in-flight drain.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              ADDR_W   = PC_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pc_ready,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_off,
  input  logic              jmp_take,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              halted,
  output logic              wrap
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                pc_valid_q, pc_valid_d;
  logic                halted_q, halted_d;
  logic                wrap_q, wrap_d;
  logic                pend_v_q, pend_v_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;

  logic                transfer;
  logic                step;
  logic                redir_v;
  logic [ADDR_W-1:0]   redir_addr;
  logic [ADDR_W-1:0]   nxt_pc;
  logic                nxt_wrap;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
    .pc         (pc_q),
    .jmp_take   (jmp_take),
    .jmp_addr   (jmp_addr),
    .br_take    (br_take),
    .br_off     (br_off),
    .pend_v     (pend_v_q),
    .pend_addr  (pend_addr_q),
    .step       (step),
    .redir_v    (redir_v),
    .redir_addr (redir_addr),
    .nxt_pc     (nxt_pc),
    .nxt_wrap   (nxt_wrap)
  );

  // Next-state, next-pc and pending-register logic.
  always_comb begin
    transfer    = pc_valid_q & pc_ready;
    step        = (state_q != ST_HALT);
    state_d     = state_q;
    pc_d        = pc_q;
    pc_valid_d  = pc_valid_q;
    halted_d    = halted_q;
    wrap_d      = 1'b0;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_RUN;
          pc_d       = RESET_PC;
          pc_valid_d = 1'b1;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (transfer) begin
          pc_d     = nxt_pc;
          wrap_d   = nxt_wrap;
          pend_v_d = 1'b0;
        end else if (redir_v) begin
          pend_v_d    = 1'b1;
          pend_addr_d = redir_addr;
        end
        if (state_q == ST_RUN) begin
          if (halt_req && (pc_ready || !pc_valid_q)) begin
            state_d    = ST_HALT;
            pc_valid_d = 1'b0;
            halted_d   = 1'b1;
          end else if (halt_req) begin
            state_d = ST_DRAIN;
          end
        end else if (transfer) begin
          state_d    = ST_HALT;
          pc_valid_d = 1'b0;
          halted_d   = 1'b1;
        end
      end

      ST_HALT: begin
        // Resume takes priority over any concurrent halt request.
        if (resume) begin
          state_d    = ST_RUN;
          pc_d       = nxt_pc;
          pend_v_d   = 1'b0;
          pc_valid_d = 1'b1;
          halted_d   = 1'b0;
        end else if (redir_v) begin
          pend_v_d    = 1'b1;
          pend_addr_d = redir_addr;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops everything, including pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      wrap_q      <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_valid_q  <= pc_valid_d;
      halted_q    <= halted_d;
      wrap_q      <= wrap_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, pc_ready, br_take, jmp_take, halt_req, resume;
  logic [4:0] br_off, jmp_addr;
  logic [4:0] pc;
  logic       pc_valid, halted, wrap;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.ADDR_W(5), .RESET_PC(5'd0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pc_ready (pc_ready),
    .br_take  (br_take),
    .br_off   (br_off),
    .jmp_take (jmp_take),
    .jmp_addr (jmp_addr),
    .halt_req (halt_req),
    .resume   (resume),
    .pc       (pc),
    .pc_valid (pc_valid),
    .halted   (halted),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; pc_ready = 0; br_take = 0; jmp_take = 0;
    halt_req = 0; resume = 0; br_off = '0; jmp_addr = '0;
    tick(); tick();
    checks++;
    if (pc !== 5'd0 || pc_valid !== 1'b0 || halted !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%0d valid=%0b halted=%0b wrap=%0b, want 0 0 0 0",
               pc, pc_valid, halted, wrap);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: valid=%0b want 0", pc_valid);
    end
  endtask

  task automatic test_sequential_wrap();
    en = 1; pc_ready = 1;
    tick();
    en = 0;
    checks++;
    if (pc !== 5'd0 || pc_valid !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL start: pc=%0d valid=%0b wrap=%0b want 0 1 0", pc, pc_valid, wrap);
    end
    for (int i = 1; i <= 37; i++) begin
      tick();
      checks++;
      if (pc !== 5'(i % 32) || pc_valid !== 1'b1 || wrap !== (i == 32)) begin
        errors++;
        $display("FAIL seq step %0d: pc=%0d valid=%0b wrap=%0b want %0d 1 %0b",
                 i, pc, pc_valid, wrap, i % 32, i == 32);
      end
    end
  endtask

  task automatic test_stall();
    // pc is 5 here
    pc_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 5'd5 || pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall %0d: pc=%0d valid=%0b want 5 1", i, pc, pc_valid);
      end
    end
    pc_ready = 1;
    tick();
    checks++;
    if (pc !== 5'd6) begin
      errors++;
      $display("FAIL stall_release: pc=%0d want 6", pc);
    end
  endtask

  task automatic test_redirect();
    tick(); tick(); tick(); tick();
    checks++;
    if (pc !== 5'd10) begin
      errors++;
      $display("FAIL reach10: pc=%0d want 10", pc);
    end
    br_take = 1; br_off = 5'b11101;
    tick();
    br_take = 0;
    checks++;
    if (pc !== 5'd7 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL branch_neg: pc=%0d wrap=%0b want 7 0", pc, wrap);
    end
    jmp_take = 1; jmp_addr = 5'd10;
    tick();
    checks++;
    if (pc !== 5'd10) begin
      errors++;
      $display("FAIL jump10: pc=%0d want 10", pc);
    end
    br_take = 1; br_off = 5'd3; jmp_addr = 5'd20;
    tick();
    br_take = 0; jmp_take = 0;
    checks++;
    if (pc !== 5'd20) begin
      errors++;
      $display("FAIL jmp_over_br: pc=%0d want 20", pc);
    end
    // branch from 20 by +15 wraps modulo 32 to 3, not a sequential wrap
    br_take = 1; br_off = 5'd15;
    tick();
    br_take = 0;
    checks++;
    if (pc !== 5'd3 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL branch_mod: pc=%0d wrap=%0b want 3 0", pc, wrap);
    end
    jmp_take = 1; jmp_addr = 5'd31;
    tick();
    jmp_addr = 5'd0;
    tick();
    jmp_take = 0;
    checks++;
    if (pc !== 5'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL jmp_to_zero: pc=%0d wrap=%0b want 0 0", pc, wrap);
    end
  endtask

  task automatic test_pending();
    jmp_take = 1; jmp_addr = 5'd12;
    tick();
    jmp_take = 0;
    pc_ready = 0;
    jmp_take = 1; jmp_addr = 5'd3;
    tick();
    jmp_addr = 5'd9;
    tick();
    jmp_take = 0;
    checks++;
    if (pc !== 5'd12 || dut.pend_v_q !== 1'b1 || pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL pend_hold: pc=%0d pend_v=%0b valid=%0b want 12 1 1",
               pc, dut.pend_v_q, pc_valid);
    end
    pc_ready = 1;
    tick();
    checks++;
    if (pc !== 5'd9 || dut.pend_v_q !== 1'b0) begin
      errors++;
      $display("FAIL pend_apply: pc=%0d pend_v=%0b want 9 0", pc, dut.pend_v_q);
    end
    tick();
    checks++;
    if (pc !== 5'd10) begin
      errors++;
      $display("FAIL pend_consumed: pc=%0d want 10", pc);
    end
  endtask

  task automatic test_halt();
    jmp_take = 1; jmp_addr = 5'd4;
    tick();
    jmp_take = 0;
    pc_ready = 0; halt_req = 1;
    tick();
    halt_req = 0;
    checks++;
    if (pc !== 5'd4 || pc_valid !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL drain: pc=%0d valid=%0b halted=%0b want 4 1 0", pc, pc_valid, halted);
    end
    pc_ready = 1;
    tick();
    checks++;
    if (pc !== 5'd5 || pc_valid !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_enter: pc=%0d valid=%0b halted=%0b want 5 0 1", pc, pc_valid, halted);
    end
    tick();
    checks++;
    if (pc !== 5'd5 || pc_valid !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_hold: pc=%0d valid=%0b halted=%0b want 5 0 1", pc, pc_valid, halted);
    end
    resume = 1; halt_req = 1;
    tick();
    resume = 0; halt_req = 0;
    checks++;
    if (pc !== 5'd5 || pc_valid !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL resume: pc=%0d valid=%0b halted=%0b want 5 1 0", pc, pc_valid, halted);
    end
    tick();
    checks++;
    if (pc !== 5'd6) begin
      errors++;
      $display("FAIL after_resume: pc=%0d want 6", pc);
    end
  endtask

  task automatic test_async_reset();
    pc_ready = 0;
    jmp_take = 1; jmp_addr = 5'd17;
    tick();
    jmp_take = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 5'd0 || pc_valid !== 1'b0 || dut.pend_v_q !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%0d valid=%0b pend_v=%0b want 0 0 0",
               pc, pc_valid, dut.pend_v_q);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    en = 1; pc_ready = 1;
    tick();
    en = 0;
    checks++;
    if (pc !== 5'd0 || pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart: pc=%0d valid=%0b want 0 1", pc, pc_valid);
    end
    tick();
    checks++;
    if (pc !== 5'd1) begin
      errors++;
      $display("FAIL no_stale_pend: pc=%0d want 1", pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential_wrap();
    test_stall();
    test_redirect();
    test_pending();
    test_halt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
